// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit: writeback consumer for the two-bank GPU register file.
// ALU results commit immediately with absolute priority; load results are
// queued in a small FIFO and drain on cycles the ALU leaves the write port idle.
module wb_regfile_unit #(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int REG_COUNT     = 32
) (
  input  logic        core_clock_i,
  input  logic        core_reset_n_i,
  input  logic        wb_valid_i,
  input  logic        wb_reg_wen_i,
  input  logic [31:0] wb_result_i,
  input  logic [4:0]  wb_dest_i,
  input  logic        wb_bank_i,
  input  logic        wb_branch_exec_i,
  input  logic        wb_branch_taken_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_data_i,
  input  logic [4:0]  ld_dest_i,
  input  logic        ld_bank_i,
  output logic        ld_busy_o,
  input  logic [4:0]  rd_a_addr_i,
  input  logic [4:0]  rd_b_addr_i,
  output logic [31:0] rd_a_data_o,
  output logic [31:0] rd_b_data_o,
  output logic        br_valid_o,
  output logic        br_taken_o,
  output logic [31:0] retire_count_o
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Register banks (no reset so they map onto RAM)
  logic [31:0] bank0_q [REG_COUNT];
  logic [31:0] bank1_q [REG_COUNT];

  // Load FIFO storage and control
  logic [31:0]      fifo_data_q [LD_FIFO_DEPTH];
  logic [4:0]       fifo_dest_q [LD_FIFO_DEPTH];
  logic             fifo_bank_q [LD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             busy_q;
  logic [31:0]      rd_a_data_q, rd_a_data_d;
  logic [31:0]      rd_b_data_q, rd_b_data_d;
  logic             br_valid_q, br_taken_q;
  logic [31:0]      retire_count_q, retire_count_d;

  logic             alu_we, push, pop;
  logic             commit_we, commit_bank;
  logic [4:0]       commit_dest;
  logic [31:0]      commit_data;

  assign ld_ready_o     = (count_q < CNT_W'(LD_FIFO_DEPTH));
  assign ld_busy_o      = busy_q;
  assign rd_a_data_o    = rd_a_data_q;
  assign rd_b_data_o    = rd_b_data_q;
  assign br_valid_o     = br_valid_q;
  assign br_taken_o     = br_taken_q;
  assign retire_count_o = retire_count_q;

  // Arbitrate the single write port, advance FIFO pointers and form read data
  always_comb begin
    alu_we         = wb_valid_i & wb_reg_wen_i & (wb_dest_i != 5'd0);
    push           = ld_valid_i & ld_ready_o;
    pop            = (count_q != '0) & ~alu_we;
    commit_we      = 1'b0;
    commit_bank    = 1'b0;
    commit_dest    = 5'd0;
    commit_data    = 32'd0;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rd_a_data_d    = 32'd0;
    rd_b_data_d    = 32'd0;
    retire_count_d = retire_count_q + 32'(wb_valid_i) + 32'(pop);

    if (alu_we) begin
      commit_we   = 1'b1;
      commit_bank = wb_bank_i;
      commit_dest = wb_dest_i;
      commit_data = wb_result_i;
    end else if (pop) begin
      commit_we   = (fifo_dest_q[rd_ptr_q] != 5'd0);
      commit_bank = fifo_bank_q[rd_ptr_q];
      commit_dest = fifo_dest_q[rd_ptr_q];
      commit_data = fifo_data_q[rd_ptr_q];
    end
    commit_we = commit_we & core_reset_n_i;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if (rd_a_addr_i != 5'd0) begin
      if (commit_we && !commit_bank && commit_dest == rd_a_addr_i)
        rd_a_data_d = commit_data;
      else
        rd_a_data_d = bank0_q[rd_a_addr_i];
    end
    if (rd_b_addr_i != 5'd0) begin
      if (commit_we && commit_bank && commit_dest == rd_b_addr_i)
        rd_b_data_d = commit_data;
      else
        rd_b_data_d = bank1_q[rd_b_addr_i];
    end
  end

  // Commit the winning write into the addressed bank
  always_ff @(posedge core_clock_i) begin
    if (commit_we && !commit_bank) bank0_q[commit_dest] <= commit_data;
    if (commit_we && commit_bank)  bank1_q[commit_dest] <= commit_data;
  end

  // Capture pushed load results into the FIFO slot at the write pointer
  always_ff @(posedge core_clock_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ld_data_i;
      fifo_dest_q[wr_ptr_q] <= ld_dest_i;
      fifo_bank_q[wr_ptr_q] <= ld_bank_i;
    end
  end

  // Control state, read ports, branch outcome and retire counter
  always_ff @(posedge core_clock_i) begin
    if (!core_reset_n_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      busy_q         <= 1'b0;
      rd_a_data_q    <= 32'd0;
      rd_b_data_q    <= 32'd0;
      br_valid_q     <= 1'b0;
      br_taken_q     <= 1'b0;
      retire_count_q <= 32'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      busy_q         <= (count_d != '0);
      rd_a_data_q    <= rd_a_data_d;
      rd_b_data_q    <= rd_b_data_d;
      br_valid_q     <= wb_valid_i & wb_branch_exec_i;
      br_taken_q     <= wb_valid_i & wb_branch_exec_i & wb_branch_taken_i;
      retire_count_q <= retire_count_d;
    end
  end

endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Consumer end of the ALU writeback interface: accepts registered ALU results (wb_*), plus load-unit results via a valid/ready handshake.
- Commits both into the two-bank GPU register file (bank 0 feeds ALU operand a, bank 1 feeds operand b).
- Provides registered read ports with write-forwarding, a registered branch outcome for fetch, and a retire counter.

Parameters:
- LD_FIFO_DEPTH, 2, load-result buffer entries; power of two, ≥2.
- REG_COUNT, 32, registers per bank; address width is 5.

Ports:
- core_clock_i  in  1  clock
- core_reset_n_i  in  1  synchronous active-low reset
- wb_valid_i  in  1  ALU writeback cycle valid
- wb_reg_wen_i  in  1  ALU register write request
- wb_result_i  in  32  ALU result
- wb_dest_i  in  5  destination register
- wb_bank_i  in  1  destination bank
- wb_branch_exec_i  in  1  branch instruction retired
- wb_branch_taken_i  in  1  branch taken
- ld_valid_i  in  1  load result valid
- ld_ready_o  out  1  load FIFO can accept
- ld_data_i  in  32  load data
- ld_dest_i  in  5  load destination register
- ld_bank_i  in  1  load destination bank
- ld_busy_o  out  1  FIFO non-empty (scheduler must not issue ALU writes to loaded regs)
- rd_a_addr_i  in  5  bank-0 read address
- rd_b_addr_i  in  5  bank-1 read address
- rd_a_data_o  out  32  bank-0 read data, 1-cycle latency
- rd_b_data_o  out  32  bank-1 read data, 1-cycle latency
- br_valid_o  out  1  branch outcome valid (1-cycle pulse)
- br_taken_o  out  1  branch taken
- retire_count_o  out  32  committed writeback count

Behaviour:
- Reset (core_reset_n_i=0 at posedge):
  - All outputs 0 except ld_ready_o=1 once out of reset.
  - FIFO pointers/count cleared; in-flight FIFO entries discarded.
  - Register array contents are not reset (RAM inference).
- Register 0 of each bank reads 0 always; writes to address 0 are dropped.
- ALU write:
  - alu_we = wb_valid_i & wb_reg_wen_i & (wb_dest_i≠0).
  - Commits at the posedge of the same cycle.
  - ALU has absolute priority; no backpressure to ALU.
- Load path:
  - Push when ld_valid_i & ld_ready_o.
  - ld_ready_o = count < LD_FIFO_DEPTH (registered count, not dependent on same-cycle pop).
  - Every load passes through the FIFO; minimum 1 cycle enqueue→commit.
  - Pop/commit FIFO head when FIFO non-empty and !alu_we.
  - Simultaneous push+pop keeps count unchanged.
  - Pointers wrap modulo LD_FIFO_DEPTH.
  - Head with dest 0 pops without writing.
- Read ports:
  - rd_*_data_o registered from the array.
  - If the committing write (ALU or FIFO pop) in the same cycle targets the same bank/address, the new data is returned (write-first forwarding).
  - Address 0 returns 0.
- Branch:
  - br_valid_o <= wb_valid_i & wb_branch_exec_i.
  - br_taken_o <= wb_valid_i & wb_branch_exec_i & wb_branch_taken_i.
  - Both are 0 otherwise.
- retire_count_o:
  - +1 per cycle with wb_valid_i, +1 per FIFO pop; +2 when both occur in the same cycle.
  - Wraps at 2^32.
- ld_busy_o = count≠0, registered.
- Ordering hazard (ALU write to a register with a load pending) is excluded by the scheduler via ld_busy_o; no unit-level check.

Test Plan:
- Reset, then ALU write bank0 r5=0xDEADBEEF (valid, wen) → next cycle read rd_a_addr=5 gives 0xDEADBEEF; retire_count_o=1.
- ALU write r0 bank1=0x1234 → rd_b_addr=0 returns 0; retire_count_o still increments.
- Same-cycle ALU write bank1 r7=0xA5A5A5A5 with rd_b_addr=7 → rd_b_data_o=0xA5A5A5A5 the following cycle (forwarding).
- Two loads back-to-back (bank0 r3=0x11, r4=0x22) while ALU writes every cycle:
  - ld_ready_o=0 after the second push; no commit while ALU writes continue.
  - ALU stops → r3 committed, then r4, on consecutive cycles.
  - ld_busy_o falls after the last pop.
- Branch: wb_valid=1, exec=1, taken=1 → br_valid_o=1, br_taken_o=1 for exactly one cycle; with wb_valid=0 (flush) both stay 0.
- Reset asserted with 2 FIFO entries held → next cycle ld_busy_o=0, ld_ready_o=1, retire_count_o=0, no pending load ever commits.
